// File: rtl/gtx_tx_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : gtx_tx_rst_seq
// Purpose  : Transmit-path reset sequencer for one GTX lane. Resets the GTX
//            PLL, waits for a filtered lock, drives INIT/TX_RATE into the
//            clock-divider reset block, waits for GTXTEST_DONE, pulses
//            TXRESET and reports TX_READY. Timeouts retry a bounded number
//            of times and then park in a sticky FAIL state.
// Ports    : CLK, RST (sync, active-high), START (restart request),
//            RATE_REQ (0 full / 1 divided), PLLLKDET (async PLL lock),
//            GTXTEST_DONE (divider reset done) ->
//            GTXRESET, INIT, TX_RATE, TXRESET, TX_READY, FAIL,
//            RETRY_CNT[2:0], STATE[2:0]
// Revision : 1.0 - initial release
// ============================================================================
module gtx_tx_rst_seq #(
   parameter int AUTO_START  = 1,
   parameter int PLL_RST_CYC = 8,     // >= 2
   parameter int LOCK_TMO    = 4095,
   parameter int DONE_TMO    = 4095,  // must exceed the divider reset time (> 2060)
   parameter int TXRST_CYC   = 4,     // >= 1
   parameter int MAX_RETRY   = 3      // 1..7
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic       RATE_REQ,
   input  logic       PLLLKDET,
   input  logic       GTXTEST_DONE,
   output logic       GTXRESET,
   output logic       INIT,
   output logic       TX_RATE,
   output logic       TXRESET,
   output logic       TX_READY,
   output logic       FAIL,
   output logic [2:0] RETRY_CNT,
   output logic [2:0] STATE
);

   localparam logic [2:0] c_idle      = 3'd0;
   localparam logic [2:0] c_pll_rst   = 3'd1;
   localparam logic [2:0] c_wait_lock = 3'd2;
   localparam logic [2:0] c_div_init  = 3'd3;
   localparam logic [2:0] c_wait_done = 3'd4;
   localparam logic [2:0] c_tx_rst    = 3'd5;
   localparam logic [2:0] c_ready     = 3'd6;
   localparam logic [2:0] c_failed    = 3'd7;

   localparam logic [11:0] c_pll_last   = 12'(PLL_RST_CYC - 1);
   localparam logic [11:0] c_lock_last  = 12'(LOCK_TMO - 1);
   localparam logic [11:0] c_div_last   = 12'd3;
   localparam logic [11:0] c_done_last  = 12'(DONE_TMO - 1);
   localparam logic [11:0] c_txrst_last = 12'(TXRST_CYC - 1);
   localparam logic [2:0]  c_max_retry  = 3'(MAX_RETRY);

   logic        sync1_q, sync1_d, sync2_q, sync2_d;
   logic        lock_s;
   logic [3:0]  filt_cnt_q, filt_cnt_d;
   logic        lock_ok_q, lock_ok_d;
   logic        auto_q, auto_d;
   logic [2:0]  state_q, state_d;
   logic [11:0] cnt_q, cnt_d;
   logic [2:0]  retry_q, retry_d;
   logic        enter;
   logic        timeout;
   logic        gtxreset_q, gtxreset_d;
   logic        init_q, init_d;
   logic        txreset_q, txreset_d;
   logic        tx_ready_q, tx_ready_d;
   logic        fail_q, fail_d;
   logic        tx_rate_q, tx_rate_d;

   assign lock_s = sync2_q;

   // Lock synchroniser and filter: lock_ok rises on the 16th consecutive
   // cycle of lock_s high and drops together with lock_s.
   always_comb begin
      sync1_d    = PLLLKDET;
      sync2_d    = sync1_q;
      filt_cnt_d = filt_cnt_q;
      lock_ok_d  = lock_ok_q;
      auto_d     = 1'b0;
      if (!lock_s) begin
         filt_cnt_d = 4'd0;
         lock_ok_d  = 1'b0;
      end else if (filt_cnt_q == 4'hF) begin
         lock_ok_d  = 1'b1;
      end else begin
         filt_cnt_d = filt_cnt_q + 4'd1;
      end
   end

   // Next-state logic; branch order encodes event priority below RST.
   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      timeout = 1'b0;
      enter   = 1'b0;
      if (START) begin
         state_d = c_pll_rst;
         retry_d = 3'd0;
         enter   = 1'b1;          // re-entry of PLL_RST also restarts its count
      end else if (!lock_s && (state_q inside {c_div_init, c_wait_done, c_tx_rst, c_ready})) begin
         state_d = c_pll_rst;
      end else begin
         case (state_q)
            c_idle:      if (auto_q) state_d = c_pll_rst;
            c_pll_rst:   if (cnt_q == c_pll_last) state_d = c_wait_lock;
            c_wait_lock: begin
               if (lock_ok_q)                 state_d = c_div_init;
               else if (cnt_q == c_lock_last) timeout = 1'b1;
            end
            c_div_init:  if (cnt_q == c_div_last) state_d = c_wait_done;
            c_wait_done: begin
               if (GTXTEST_DONE)              state_d = c_tx_rst;
               else if (cnt_q == c_done_last) timeout = 1'b1;
            end
            c_tx_rst:    if (cnt_q == c_txrst_last) state_d = c_ready;
            c_ready:     if (RATE_REQ != tx_rate_q) state_d = c_div_init;
            default:     state_d = state_q;   // FAILED holds until START/RST
         endcase
         if (timeout) begin
            if (retry_q != c_max_retry) retry_d = retry_q + 3'd1;
            state_d = (retry_d == c_max_retry) ? c_failed : c_pll_rst;
         end
      end
      if (state_d != state_q) enter = 1'b1;
      // Counter saturates in the open-ended states instead of wrapping.
      if (enter)                 cnt_d = 12'd0;
      else if (cnt_q == 12'hFFF) cnt_d = cnt_q;
      else                       cnt_d = cnt_q + 12'd1;
   end

   // Outputs decoded from the next state so they change with STATE.
   always_comb begin
      gtxreset_d = state_d inside {c_idle, c_pll_rst, c_failed};
      init_d     = !(state_d inside {c_wait_done, c_tx_rst, c_ready});
      txreset_d  = (state_d != c_ready);
      tx_ready_d = (state_d == c_ready);
      fail_d     = (state_d == c_failed);
      tx_rate_d  = (enter && state_d == c_div_init) ? RATE_REQ : tx_rate_q;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         filt_cnt_q <= 4'd0;
         lock_ok_q  <= 1'b0;
         auto_q     <= (AUTO_START != 0);
         state_q    <= c_idle;
         cnt_q      <= 12'd0;
         retry_q    <= 3'd0;
         gtxreset_q <= 1'b1;
         init_q     <= 1'b1;
         txreset_q  <= 1'b1;
         tx_ready_q <= 1'b0;
         fail_q     <= 1'b0;
         tx_rate_q  <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         filt_cnt_q <= filt_cnt_d;
         lock_ok_q  <= lock_ok_d;
         auto_q     <= auto_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         retry_q    <= retry_d;
         gtxreset_q <= gtxreset_d;
         init_q     <= init_d;
         txreset_q  <= txreset_d;
         tx_ready_q <= tx_ready_d;
         fail_q     <= fail_d;
         tx_rate_q  <= tx_rate_d;
      end
   end

   assign GTXRESET  = gtxreset_q;
   assign INIT      = init_q;
   assign TX_RATE   = tx_rate_q;
   assign TXRESET   = txreset_q;
   assign TX_READY  = tx_ready_q;
   assign FAIL      = fail_q;
   assign RETRY_CNT = retry_q;
   assign STATE     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_gtx_tx_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_gtx_tx_rst_seq
// Purpose  : Directed self-checking bench for gtx_tx_rst_seq with default
//            parameters: nominal bring-up, rate change, lock loss, lock
//            timeout to FAILED, lock glitch filtering, START priority over
//            a timeout, and RST mid-sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gtx_tx_rst_seq;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       START = 1'b0;
   logic       RATE_REQ = 1'b0;
   logic       PLLLKDET = 1'b0;
   logic       GTXTEST_DONE = 1'b0;
   logic       GTXRESET, INIT, TX_RATE, TXRESET, TX_READY, FAIL;
   logic [2:0] RETRY_CNT, STATE;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   n;
   bit   ok;

   localparam logic [11:0] c_rst_vec = {3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};

   gtx_tx_rst_seq dut (
      .CLK          (CLK),
      .RST          (RST),
      .START        (START),
      .RATE_REQ     (RATE_REQ),
      .PLLLKDET     (PLLLKDET),
      .GTXTEST_DONE (GTXTEST_DONE),
      .GTXRESET     (GTXRESET),
      .INIT         (INIT),
      .TX_RATE      (TX_RATE),
      .TXRESET      (TXRESET),
      .TX_READY     (TX_READY),
      .FAIL         (FAIL),
      .RETRY_CNT    (RETRY_CNT),
      .STATE        (STATE)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [11:0] outs();
      return {STATE, GTXRESET, INIT, TXRESET, TX_READY, FAIL, RETRY_CNT, TX_RATE};
   endfunction

   task automatic test_reset();
      for (int i = 0; i < 3; i++) tick();
      n_checks++;
      if (outs() !== c_rst_vec) begin
         n_fail++;
         $display("FAIL reset_values: got %h want %h", outs(), c_rst_vec);
      end
   endtask

   task automatic test_nominal();
      RST = 1'b0;
      tick();
      n_checks++;
      if (STATE !== 3'd1) begin n_fail++; $display("FAIL auto_start_state: got %0d want 1", STATE); end
      n = 0; ok = 1'b1;
      while (STATE == 3'd1 && n < 100) begin
         if (GTXRESET !== 1'b1) ok = 1'b0;
         n++; tick();
      end
      n_checks++;
      if (n !== 8 || !ok) begin n_fail++; $display("FAIL pll_rst_len: got %0d ok=%0d want 8 ok=1", n, ok); end
      n_checks++;
      if (STATE !== 3'd2 || GTXRESET !== 1'b0) begin
         n_fail++; $display("FAIL wait_lock_entry: got state %0d gtxreset %0d want 2 0", STATE, GTXRESET);
      end
      for (int i = 0; i < 11; i++) tick();
      PLLLKDET = 1'b1;
      n = 0;
      while (STATE != 3'd3 && n < 100) begin tick(); n++; end
      n_checks++;
      if (n !== 19) begin n_fail++; $display("FAIL lock_latency: got %0d want 19", n); end
      n = 0; ok = 1'b1;
      while (STATE == 3'd3 && n < 20) begin
         if (INIT !== 1'b1) ok = 1'b0;
         n++; tick();
      end
      n_checks++;
      if (n !== 4 || !ok || STATE !== 3'd4 || INIT !== 1'b0) begin
         n_fail++; $display("FAIL div_init_len: got %0d ok=%0d state %0d init %0d want 4 1 4 0", n, ok, STATE, INIT);
      end
      for (int i = 0; i < 2099; i++) tick();
      GTXTEST_DONE = 1'b1;
      tick();
      GTXTEST_DONE = 1'b0;
      n_checks++;
      if (STATE !== 3'd5 || TXRESET !== 1'b1) begin
         n_fail++; $display("FAIL tx_rst_entry: got state %0d txreset %0d want 5 1", STATE, TXRESET);
      end
      n = 0;
      while (TXRESET === 1'b1 && n < 100) begin tick(); n++; end
      n_checks++;
      if (n !== 4) begin n_fail++; $display("FAIL txreset_fall: got %0d want 4", n); end
      n_checks++;
      if ({STATE, TX_READY, RETRY_CNT, GTXRESET, FAIL} !== {3'd6, 1'b1, 3'd0, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL ready_outputs: got state %0d ready %0d retry %0d gtxrst %0d fail %0d want 6 1 0 0 0",
                             STATE, TX_READY, RETRY_CNT, GTXRESET, FAIL);
      end
   endtask

   task automatic test_rate_change();
      RATE_REQ = 1'b1;
      tick();
      n_checks++;
      if ({STATE, TX_READY, INIT, TX_RATE, GTXRESET} !== {3'd3, 1'b0, 1'b1, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL rate_change_entry: got state %0d ready %0d init %0d rate %0d gtxrst %0d want 3 0 1 1 0",
                             STATE, TX_READY, INIT, TX_RATE, GTXRESET);
      end
      ok = 1'b1;
      for (int i = 0; i < 4; i++) begin tick(); if (GTXRESET !== 1'b0) ok = 1'b0; end
      n_checks++;
      if (STATE !== 3'd4) begin n_fail++; $display("FAIL rate_wait_done: got %0d want 4", STATE); end
      for (int i = 0; i < 5; i++) begin tick(); if (GTXRESET !== 1'b0) ok = 1'b0; end
      GTXTEST_DONE = 1'b1;
      tick();
      GTXTEST_DONE = 1'b0;
      for (int i = 0; i < 4; i++) begin tick(); if (GTXRESET !== 1'b0) ok = 1'b0; end
      n_checks++;
      if ({STATE, TX_READY, TX_RATE} !== {3'd6, 1'b1, 1'b1} || !ok) begin
         n_fail++; $display("FAIL rate_reready: got state %0d ready %0d rate %0d gtx_low %0d want 6 1 1 1",
                             STATE, TX_READY, TX_RATE, ok);
      end
   endtask

   task automatic test_lock_loss(input logic [2:0] exp_retry);
      PLLLKDET = 1'b0;
      tick(); tick();
      n_checks++;
      if (TX_READY !== 1'b1) begin n_fail++; $display("FAIL loss_too_early: got ready %0d want 1", TX_READY); end
      tick();
      n_checks++;
      if ({STATE, TX_READY, GTXRESET, RETRY_CNT} !== {3'd1, 1'b0, 1'b1, exp_retry}) begin
         n_fail++; $display("FAIL lock_loss: got state %0d ready %0d gtxrst %0d retry %0d want 1 0 1 %0d",
                             STATE, TX_READY, GTXRESET, RETRY_CNT, exp_retry);
      end
   endtask

   task automatic test_lock_timeout();
      for (int k = 0; k < 3; k++) begin
         n = 0;
         while (STATE == 3'd1 && n < 50) begin tick(); n++; end
         n = 0;
         while (STATE == 3'd2 && n < 5000) begin tick(); n++; end
         n_checks++;
         if (n !== 4095) begin n_fail++; $display("FAIL lock_tmo_len%0d: got %0d want 4095", k, n); end
         if (k < 2) begin
            n_checks++;
            if (STATE !== 3'd1 || RETRY_CNT !== 3'(k + 1)) begin
               n_fail++; $display("FAIL lock_tmo_retry%0d: got state %0d retry %0d want 1 %0d", k, STATE, RETRY_CNT, k + 1);
            end
         end
      end
      for (int i = 0; i < 20; i++) tick();
      n_checks++;
      if ({STATE, FAIL, RETRY_CNT, GTXRESET} !== {3'd7, 1'b1, 3'd3, 1'b1}) begin
         n_fail++; $display("FAIL failed_state: got state %0d fail %0d retry %0d gtxrst %0d want 7 1 3 1",
                             STATE, FAIL, RETRY_CNT, GTXRESET);
      end
      START = 1'b1;
      tick();
      START = 1'b0;
      n_checks++;
      if ({STATE, FAIL, RETRY_CNT} !== {3'd1, 1'b0, 3'd0}) begin
         n_fail++; $display("FAIL start_from_failed: got state %0d fail %0d retry %0d want 1 0 0", STATE, FAIL, RETRY_CNT);
      end
   endtask

   task automatic test_lock_glitch();
      n = 0;
      while (STATE == 3'd1 && n < 50) begin tick(); n++; end
      n = 0;
      while (STATE == 3'd2 && n < 5000) begin tick(); n++; end
      n_checks++;
      if (STATE !== 3'd1 || RETRY_CNT !== 3'd1) begin
         n_fail++; $display("FAIL single_timeout: got state %0d retry %0d want 1 1", STATE, RETRY_CNT);
      end
      PLLLKDET = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      PLLLKDET = 1'b0;
      tick();
      PLLLKDET = 1'b1;
      n = 0;
      while (STATE != 3'd3 && n < 100) begin tick(); n++; end
      n_checks++;
      if (n !== 19) begin n_fail++; $display("FAIL glitch_latency: got %0d want 19", n); end
      n = 0;
      while (STATE != 3'd4 && n < 20) begin tick(); n++; end
      for (int i = 0; i < 5; i++) tick();
      GTXTEST_DONE = 1'b1;
      tick();
      GTXTEST_DONE = 1'b0;
      n = 0;
      while (STATE != 3'd6 && n < 20) begin tick(); n++; end
      n_checks++;
      if ({STATE, TX_READY, RETRY_CNT} !== {3'd6, 1'b1, 3'd1}) begin
         n_fail++; $display("FAIL glitch_ready: got state %0d ready %0d retry %0d want 6 1 1", STATE, TX_READY, RETRY_CNT);
      end
   endtask

   task automatic test_priority();
      PLLLKDET = 1'b1;
      n = 0;
      while (STATE != 3'd4 && n < 100) begin tick(); n++; end
      for (int i = 0; i < 4094; i++) tick();
      n_checks++;
      if (STATE !== 3'd4) begin n_fail++; $display("FAIL done_tmo_early: got state %0d want 4", STATE); end
      START = 1'b1;
      tick();
      START = 1'b0;
      n_checks++;
      if ({STATE, RETRY_CNT} !== {3'd1, 3'd0}) begin
         n_fail++; $display("FAIL start_over_timeout: got state %0d retry %0d want 1 0", STATE, RETRY_CNT);
      end
   endtask

   task automatic test_rst_mid();
      n = 0;
      while (STATE != 3'd4 && n < 100) begin tick(); n++; end
      for (int i = 0; i < 5; i++) tick();
      n_checks++;
      if (STATE !== 3'd4 || TX_RATE !== 1'b1) begin
         n_fail++; $display("FAIL pre_rst_state: got state %0d rate %0d want 4 1", STATE, TX_RATE);
      end
      RST = 1'b1;
      tick();
      n_checks++;
      if (outs() !== c_rst_vec) begin
         n_fail++; $display("FAIL rst_mid_sequence: got %h want %h", outs(), c_rst_vec);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_rate_change();
      test_lock_loss(3'd0);
      test_lock_timeout();
      test_lock_glitch();
      test_lock_loss(3'd1);
      test_priority();
      test_rst_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
